// File: rtl/hdmi_send.sv
// hdmi_send: Avalon-ST to parallel HDMI video transmitter.
//
// Generates the raster timing (HS/VS/DE) for a programmable video mode in the
// pixel clock domain. It pulls one 32-bit beat per active pixel from an ST
// sink. The stream is aligned so that the startofpacket beat lands on pixel
// (0,0) of a frame.
//
// Ports
//   hdmi_clk, hdmi_rst       pixel clock, asynchronous active-high reset
//   st_data[31:0]            pixel beat, [23:0] = RGB, [31:24] ignored
//   st_valid, st_ready       ST handshake (st_ready is combinational)
//   st_startofpacket/endof.. frame delimiters
//   hdmi_data[23:0]          registered pixel data to the PHY (0 when blanked)
//   hdmi_hs, hdmi_vs, hdmi_de registered sync / data-enable
//   underflow                1-cycle pulse: active pixel with no valid beat
//   frame_err                1-cycle pulse: SOP/EOP misaligned with raster
//   pattern_sel              (only with HDMI_SEND_PATTERN_EN) colour-bar mode
//
// Build option: define HDMI_SEND_PATTERN_EN to add the pattern_sel port and
// the built-in 8-bar colour test pattern.
module hdmi_send #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic        hdmi_clk,
  input  logic        hdmi_rst,
`ifdef HDMI_SEND_PATTERN_EN
  input  logic        pattern_sel,
`endif
  input  logic [31:0] st_data,
  input  logic        st_valid,
  input  logic        st_startofpacket,
  input  logic        st_endofpacket,
  output logic        st_ready,
  output logic [23:0] hdmi_data,
  output logic        hdmi_hs,
  output logic        hdmi_vs,
  output logic        hdmi_de,
  output logic        underflow,
  output logic        frame_err
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = (H_TOT > 1) ? $clog2(H_TOT) : 1;
  localparam int VW    = (V_TOT > 1) ? $clog2(V_TOT) : 1;

  // Thresholds carry one extra bit so a sync end equal to the total never wraps.
  localparam logic [HW:0]   H_ACT_C  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]   H_LAST_C = (HW+1)'(H_ACTIVE - 1);
  localparam logic [HW:0]   H_SB_C   = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0]   H_SE_C   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_MAX_C  = HW'(H_TOT - 1);
  localparam logic [VW:0]   V_ACT_C  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0]   V_LAST_C = (VW+1)'(V_ACTIVE - 1);
  localparam logic [VW:0]   V_SB_C   = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0]   V_SE_C   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_MAX_C  = VW'(V_TOT - 1);

  localparam logic HS_LVL = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_LVL = (VS_POL != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t          state_r;
  logic [HW-1:0]   h_cnt_r;
  logic [VW-1:0]   v_cnt_r;
  logic [HW:0]     h_ext_s;
  logic [VW:0]     v_ext_s;
  logic            act_s;
  logic            origin_s;
  logic            last_s;
  logic            hs_on_s;
  logic            vs_on_s;

  // Decision for the current pixel slot assuming the stream is locked to it
  state_t          run_next_s;
  logic            run_ready_s;
  logic [23:0]     run_data_s;
  logic            run_uf_s;
  logic            run_fe_s;

  // Stream-driven FSM result
  state_t          core_next_s;
  logic            core_ready_s;
  logic [23:0]     core_data_s;
  logic            core_uf_s;
  logic            core_fe_s;

  // Final selection (stream or test pattern)
  state_t          sel_next_s;
  logic            sel_ready_s;
  logic [23:0]     sel_data_s;
  logic            sel_uf_s;
  logic            sel_fe_s;

  logic            unused_s;

  assign unused_s = ^st_data[31:24];

  assign h_ext_s  = {1'b0, h_cnt_r};
  assign v_ext_s  = {1'b0, v_cnt_r};
  assign act_s    = (h_ext_s < H_ACT_C) && (v_ext_s < V_ACT_C);
  assign origin_s = (h_cnt_r == '0) && (v_cnt_r == '0);
  assign last_s   = (h_ext_s == H_LAST_C) && (v_ext_s == V_LAST_C);
  assign hs_on_s  = (h_ext_s >= H_SB_C) && (h_ext_s < H_SE_C);
  assign vs_on_s  = (v_ext_s >= V_SB_C) && (v_ext_s < V_SE_C);

  // Raster position counters; v advances when h wraps
  always_ff @(posedge hdmi_clk or posedge hdmi_rst) begin
    if (hdmi_rst) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (h_cnt_r == H_MAX_C) begin
      h_cnt_r <= '0;
      if (v_cnt_r == V_MAX_C) begin
        v_cnt_r <= '0;
      end else begin
        v_cnt_r <= v_cnt_r + VW'(1'b1);
      end
    end else begin
      h_cnt_r <= h_cnt_r + HW'(1'b1);
    end
  end

  // Per-pixel handling while the stream is locked to the raster
  always_comb begin
    run_next_s  = RUN;
    run_data_s  = 24'h000000;
    run_uf_s    = 1'b0;
    run_fe_s    = 1'b0;
    // A SOP away from (0,0) is refused so it can be replayed at the next origin.
    run_ready_s = act_s && !(st_startofpacket && !origin_s);
    if (!act_s) begin
      run_next_s = RUN;
    end else if (!st_valid) begin
      // Slot is lost; the raster never stalls.
      run_uf_s = 1'b1;
    end else if (st_startofpacket && !origin_s) begin
      run_fe_s   = 1'b1;
      run_next_s = ARMED;
    end else begin
      run_data_s = st_data[23:0];
      // Missing SOP at origin, missing EOP at the last pixel, or early EOP.
      if ((origin_s && !st_startofpacket) || (last_s != st_endofpacket)) begin
        run_fe_s   = 1'b1;
        run_next_s = SEEK;
      end else begin
        run_next_s = RUN;
      end
    end
  end

  // Next-state and slot outputs of the stream alignment FSM
  always_comb begin
    core_next_s  = state_r;
    core_ready_s = 1'b0;
    core_data_s  = 24'h000000;
    core_uf_s    = 1'b0;
    core_fe_s    = 1'b0;
    case (state_r)
      SEEK: begin
        // Drain anything that is not a frame start; hold the SOP beat.
        core_ready_s = ~st_startofpacket;
        if (st_valid && st_startofpacket) begin
          core_next_s = ARMED;
        end else begin
          core_next_s = SEEK;
        end
      end
      ARMED: begin
        // The origin pixel itself is already served as a locked slot.
        if (origin_s) begin
          core_next_s  = run_next_s;
          core_ready_s = run_ready_s;
          core_data_s  = run_data_s;
          core_uf_s    = run_uf_s;
          core_fe_s    = run_fe_s;
        end else begin
          core_next_s = ARMED;
        end
      end
      RUN: begin
        core_next_s  = run_next_s;
        core_ready_s = run_ready_s;
        core_data_s  = run_data_s;
        core_uf_s    = run_uf_s;
        core_fe_s    = run_fe_s;
      end
      default: begin
        core_next_s = SEEK;
      end
    endcase
  end

`ifdef HDMI_SEND_PATTERN_EN
  localparam int BW = HW + 3;

  logic [BW-1:0] bar_num_s;
  logic [2:0]    bar_idx_s;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  // Bar index = h_cnt*8/H_ACTIVE, saturated for blanking columns
  assign bar_num_s = {h_cnt_r, 3'b000} / BW'(H_ACTIVE);
  assign bar_idx_s = (bar_num_s > BW'(7)) ? 3'd7 : bar_num_s[2:0];

  // Choose between the test pattern and the stream path
  always_comb begin
    sel_next_s  = core_next_s;
    sel_ready_s = core_ready_s;
    sel_data_s  = core_data_s;
    sel_uf_s    = core_uf_s;
    sel_fe_s    = core_fe_s;
    if (pattern_sel) begin
      sel_next_s  = SEEK;
      sel_ready_s = 1'b0;
      sel_data_s  = act_s ? bar_colour(bar_idx_s) : 24'h000000;
      sel_uf_s    = 1'b0;
      sel_fe_s    = 1'b0;
    end else begin
      sel_next_s  = core_next_s;
      sel_ready_s = core_ready_s;
      sel_data_s  = core_data_s;
      sel_uf_s    = core_uf_s;
      sel_fe_s    = core_fe_s;
    end
  end
`else
  assign sel_next_s  = core_next_s;
  assign sel_ready_s = core_ready_s;
  assign sel_data_s  = core_data_s;
  assign sel_uf_s    = core_uf_s;
  assign sel_fe_s    = core_fe_s;
`endif

  // Ready drops immediately on reset, without waiting for a clock edge
  assign st_ready = ~hdmi_rst & sel_ready_s;

  // FSM state register
  always_ff @(posedge hdmi_clk or posedge hdmi_rst) begin
    if (hdmi_rst) begin
      state_r <= SEEK;
    end else begin
      state_r <= sel_next_s;
    end
  end

  // Registered video outputs and status pulses (one cycle behind counters)
  always_ff @(posedge hdmi_clk or posedge hdmi_rst) begin
    if (hdmi_rst) begin
      hdmi_data <= 24'h000000;
      hdmi_de   <= 1'b0;
      hdmi_hs   <= ~HS_LVL;
      hdmi_vs   <= ~VS_LVL;
      underflow <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      hdmi_data <= sel_data_s;
      hdmi_de   <= act_s;
      hdmi_hs   <= hs_on_s ? HS_LVL : ~HS_LVL;
      hdmi_vs   <= vs_on_s ? VS_LVL : ~VS_LVL;
      underflow <= sel_uf_s;
      frame_err <= sel_fe_s;
    end
  end

endmodule

// File: tb/tb_hdmi_send.sv
// Testbench for hdmi_send on a small raster (H 8/2/2/2, V 4/1/1/1).
// A source queue of beats drives the ST sink; a raster-level reference model
// pushes expected outputs into a scoreboard that a monitor process drains.
module tb_hdmi_send;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HSW = 2;
  localparam int HB = 2;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VSW = 1;
  localparam int VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;

  localparam int M_SEEK   = 0;
  localparam int M_ARMED  = 1;
  localparam int M_LOCKED = 2;

  logic        hdmi_clk;
  logic        hdmi_rst;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_startofpacket;
  logic        st_endofpacket;
  logic        st_ready;
  logic [23:0] hdmi_data;
  logic        hdmi_hs;
  logic        hdmi_vs;
  logic        hdmi_de;
  logic        underflow;
  logic        frame_err;

  hdmi_send #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1), .VS_POL(1)
  ) dut (
    .hdmi_clk(hdmi_clk),
    .hdmi_rst(hdmi_rst),
    .st_data(st_data),
    .st_valid(st_valid),
    .st_startofpacket(st_startofpacket),
    .st_endofpacket(st_endofpacket),
    .st_ready(st_ready),
    .hdmi_data(hdmi_data),
    .hdmi_hs(hdmi_hs),
    .hdmi_vs(hdmi_vs),
    .hdmi_de(hdmi_de),
    .underflow(underflow),
    .frame_err(frame_err)
  );

  typedef struct {
    logic [31:0] data;
    bit          sop;
    bit          eop;
    int          idle;
  } beat_t;

  typedef struct {
    logic [23:0] data;
    bit          de;
    bit          hs;
    bit          vs;
    bit          uf;
    bit          fe;
  } exp_t;

  beat_t src_q[$];
  exp_t  sb_q[$];
  int    checks = 0;
  int    failures = 0;
  int    fail_prints = 0;

  initial hdmi_clk = 1'b0;
  always #5 hdmi_clk = ~hdmi_clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s: got %0h expected %0h at time %0t", name, got, want, $time);
      end
    end
  endtask

  // Frame of n beats; eop_at < 0 means no EOP; idle_n invalid cycles before beat idle_at.
  task automatic push_frame(input int n, input int eop_at, input int idle_at,
                            input int idle_n, input bit rnd);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = rnd ? $urandom() : {8'($urandom_range(0, 255)), 16'h0000, 8'(i)};
      b.sop  = (i == 0);
      b.eop  = (i == eop_at);
      b.idle = (i == idle_at) ? idle_n : 0;
      if (rnd && ($urandom_range(0, 15) == 0)) b.idle = $urandom_range(1, 3);
      src_q.push_back(b);
    end
  endtask

  // Monitor: compare each registered output cycle with the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(posedge hdmi_clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("hdmi_data", 32'(hdmi_data), 32'(e.data));
        check("hdmi_de", 32'(hdmi_de), 32'(e.de));
        check("hdmi_hs", 32'(hdmi_hs), 32'(e.hs));
        check("hdmi_vs", 32'(hdmi_vs), 32'(e.vs));
        check("underflow", 32'(underflow), 32'(e.uf));
        check("frame_err", 32'(frame_err), 32'(e.fe));
      end
    end
  end

  // Stimulus, reference model and reset checks
  initial begin
    int    t, h, v, mode, src_idx, idle_left, tail_start;
    bit    act, origin, last, e_ready, shown, done;
    exp_t  e;

    hdmi_rst = 1'b1;
    st_valid = 1'b1;
    st_startofpacket = 1'b0;
    st_endofpacket = 1'b0;
    st_data = 32'h12345678;

    // Three junk beats, then the directed scenarios
    for (int i = 0; i < 3; i++) src_q.push_back('{32'hDEAD0000 + 32'(i), 1'b0, 1'b0, 0});
    repeat (3) push_frame(32, 31, -1, 0, 1'b0);
    push_frame(32, 31, 13, 2, 1'b0);          // valid drops at pixels 5-6 of line 1
    push_frame(20, -1, -1, 0, 1'b0);          // SOP of next frame arrives at pixel 20
    push_frame(32, 31, -1, 0, 1'b0);
    push_frame(32, -1, -1, 0, 1'b0);          // EOP missing on beat 31
    push_frame(32, 31, -1, 0, 1'b0);
    push_frame(16, 15, -1, 0, 1'b0);          // early EOP
    push_frame(32, 31, -1, 0, 1'b0);
    for (int f = 0; f < 8; f++) begin
      case ($urandom_range(0, 3))
        0: push_frame($urandom_range(4, 31), -1, -1, 0, 1'b1);
        1: push_frame(32, -1, -1, 0, 1'b1);
        2: begin
          int n;
          n = $urandom_range(2, 31);
          push_frame(n, n - 1, -1, 0, 1'b1);
        end
        default: push_frame(32, 31, -1, 0, 1'b1);
      endcase
    end
    tail_start = src_q.size();
    repeat (4) push_frame(32, 31, -1, 0, 1'b0);

    // Reset values while reset is held (valid high, non-SOP: ready must still be 0)
    repeat (3) @(posedge hdmi_clk);
    #1;
    check("reset_data", 32'(hdmi_data), 32'h0);
    check("reset_de", 32'(hdmi_de), 32'h0);
    check("reset_hs", 32'(hdmi_hs), 32'h0);
    check("reset_vs", 32'(hdmi_vs), 32'h0);
    check("reset_underflow", 32'(underflow), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_st_ready", 32'(st_ready), 32'h0);

    @(negedge hdmi_clk);
    hdmi_rst = 1'b0;
    mode = M_SEEK;
    t = 0;
    src_idx = 0;
    idle_left = src_q[0].idle;
    done = 1'b0;

    while (!done && (t < 20000)) begin
      if ((src_idx < src_q.size()) && (idle_left == 0)) begin
        st_valid = 1'b1;
        st_data = src_q[src_idx].data;
        st_startofpacket = src_q[src_idx].sop;
        st_endofpacket = src_q[src_idx].eop;
      end else begin
        st_valid = 1'b0;
        st_data = $urandom();
        st_startofpacket = 1'b0;
        st_endofpacket = 1'b0;
      end
      #1;

      // Raster position from elapsed cycles
      h = t % HT;
      v = (t / HT) % VT;
      act = (h < HA) && (v < VA);
      origin = (h == 0) && (v == 0);
      last = (h == HA - 1) && (v == VA - 1);
      e.data = 24'h0;
      e.de = act;
      e.hs = (h >= HA + HF) && (h < HA + HF + HSW);
      e.vs = (v >= VA + VF) && (v < VA + VF + VSW);
      e.uf = 1'b0;
      e.fe = 1'b0;
      shown = 1'b0;

      if (mode == M_SEEK) begin
        e_ready = !st_startofpacket;
        if (st_valid && st_startofpacket) mode = M_ARMED;
      end else if ((mode == M_ARMED) && !origin) begin
        e_ready = 1'b0;
      end else begin
        mode = M_LOCKED;
        e_ready = act && !(st_startofpacket && !origin);
        if (act) begin
          if (!st_valid) begin
            e.uf = 1'b1;
          end else if (st_startofpacket && !origin) begin
            e.fe = 1'b1;
            mode = M_ARMED;
          end else begin
            e.data = st_data[23:0];
            shown = 1'b1;
            if (origin && !st_startofpacket) begin
              e.fe = 1'b1;
              mode = M_SEEK;
            end else if (last && !st_endofpacket) begin
              e.fe = 1'b1;
              mode = M_SEEK;
            end else if (!last && st_endofpacket) begin
              e.fe = 1'b1;
              mode = M_SEEK;
            end
          end
        end
      end

      check("st_ready", 32'(st_ready), 32'(e_ready));
      sb_q.push_back(e);

      if ((src_idx >= tail_start) && shown && (h == 3) && (v == 1) && (e.data != 24'h0))
        done = 1'b1;

      // Source follows the real handshake
      if (st_valid && st_ready) begin
        src_idx++;
        idle_left = (src_idx < src_q.size()) ? src_q[src_idx].idle : 0;
      end else if (!st_valid && (idle_left > 0)) begin
        idle_left--;
      end

      t++;
      if (!done) @(negedge hdmi_clk);
    end

    check("reached_tail_run", 32'(done), 32'h1);

    // Asynchronous reset in the middle of an active line
    @(posedge hdmi_clk);
    #2;
    check("pre_reset_de", 32'(hdmi_de), 32'h1);
    st_valid = 1'b1;
    st_startofpacket = 1'b0;
    hdmi_rst = 1'b1;
    #1;
    check("async_rst_de", 32'(hdmi_de), 32'h0);
    check("async_rst_hs", 32'(hdmi_hs), 32'h0);
    check("async_rst_vs", 32'(hdmi_vs), 32'h0);
    check("async_rst_data", 32'(hdmi_data), 32'h0);
    check("async_rst_st_ready", 32'(st_ready), 32'h0);
    check("async_rst_frame_err", 32'(frame_err), 32'h0);

    // Timing restarts at (0,0): first line after release
    @(negedge hdmi_clk);
    hdmi_rst = 1'b0;
    st_valid = 1'b0;
    for (int k = 0; k < HT + 2; k++) begin
      @(posedge hdmi_clk);
      #1;
      check("restart_de", 32'(hdmi_de), 32'((k % HT) < HA));
      check("restart_hs", 32'(hdmi_hs), 32'(((k % HT) >= HA + HF) && ((k % HT) < HA + HF + HSW)));
      check("restart_data", 32'(hdmi_data), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
